bullet_bill_scheduler: RTL and testbench

Owns the three BulletBill slots that the graphics generator draws. It allocates a free slot on each fire request, advances every live bullet one cell per movement period, and retires bullets at the right edge. It detects collisions against the DDAVER grid and reports each hit to the enemy-grid owner over a valid/ready handshake. It sits between player input / frame timing and the graphics generator's `bulletBill*` inputs.

---
 rtl/color_crasher_pkg.sv | 26 ++
 rtl/ddaver_cell_decode.sv | 19 +
 rtl/bullet_bill_scheduler.sv | 155 +++++++++++++++
 tb/tb_bullet_bill_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/color_crasher_pkg.sv
// Shared types and constants for the Color Crasher playfield: slot records,
// scheduler states and grid geometry.
package color_crasher_pkg;

    localparam int BSIZE     = 40;
    localparam int GRID_COLS = 16;
    localparam int GRID_ROWS = 12;
    localparam int DD_ROWS   = 5;
    localparam int DD_COLS   = 6;

    typedef logic [11:0] rgb_t;

    typedef struct packed {
        logic       active;
        rgb_t       color;
        logic [3:0] x;
        logic [3:0] y;
    } bullet_slot_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STEP     = 2'd1,
        ST_HIT_WAIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/ddaver_cell_decode.sv
// Maps a playfield cell (row y, column nx) onto the DDAVER grid: ddavers sit
// on odd rows up to 9 and on even columns from 4 upward.
module ddaver_cell_decode
    import color_crasher_pkg::*;
(
    input  logic [3:0]                 y,
    input  logic [3:0]                 nx,
    output logic                       isCell,
    output logic [$clog2(DD_ROWS)-1:0] ddRow,
    output logic [$clog2(DD_COLS)-1:0] ddCol
);

    always_comb begin
        isCell = y[0] && (y <= 4'd9) && !nx[0] && (nx >= 4'd4);
        ddRow  = y[3:1];
        ddCol  = nx[3:1] - 3'd2;
    end

endmodule

// File: rtl/bullet_bill_scheduler.sv
// BulletBill slot owner: allocation on fire, periodic stepping, edge retirement
// and hit reporting. Define BULLET_PIERCE_EN to let mismatched hits pass through.
module bullet_bill_scheduler
    import color_crasher_pkg::*;
#(
    parameter int NUM_BULLETS = 3,
    parameter int MOVE_DIV    = 4,
    parameter int X_MAX       = 15
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             frameTick,
    input  logic                             fireReq,
    input  rgb_t                             fireColor,
    input  logic [3:0]                       blockieee,
    input  rgb_t [0:4][0:5]                  ddavers,
    input  logic                             hitReady,
    output logic                             fireAck,
    output logic                             fireDrop,
    output logic                             hitValid,
    output logic [2:0]                       hitRow,
    output logic [2:0]                       hitCol,
    output logic                             hitMatch,
    output rgb_t [0:NUM_BULLETS-1]           bulletBillColor,
    output logic [0:NUM_BULLETS-1][3:0]      bulletBillXLoc,
    output logic [0:NUM_BULLETS-1][3:0]      bulletBillYLoc
);

    localparam logic [1:0] IDLE     = ST_IDLE;
    localparam logic [1:0] STEP     = ST_STEP;
    localparam logic [1:0] HIT_WAIT = ST_HIT_WAIT;
    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

    bullet_slot_t [NUM_BULLETS-1:0] slots;
    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] frame_cnt;
    logic          step_pending;

    bullet_slot_t  cur;
    logic [3:0]    nx;
    logic          is_cell, wrap, last, retire, hit, have_free;
    logic [2:0]    dd_row, dd_col;
    logic [IW-1:0] free_idx;
    rgb_t          cell_color;

    assign cur  = slots[idx];
    assign nx   = cur.x + 4'd1;
    assign wrap = frameTick && (frame_cnt == CW'(MOVE_DIV - 1));
    assign last = (idx == IW'(NUM_BULLETS - 1));

    ddaver_cell_decode u_decode (
        .y      (cur.y),
        .nx     (nx),
        .isCell (is_cell),
        .ddRow  (dd_row),
        .ddCol  (dd_col)
    );

    always_comb begin
        cell_color = is_cell ? ddavers[dd_row][dd_col] : '0;
        retire     = cur.active && (cur.x == 4'(X_MAX));
        hit        = cur.active && !retire && (cell_color != '0);
        have_free  = 1'b0;
        free_idx   = '0;
        // Scan downward so the lowest free index wins.
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!slots[i].active) begin
                have_free = 1'b1;
                free_idx  = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots        <= '0;
            state        <= IDLE;
            idx          <= '0;
            frame_cnt    <= '0;
            step_pending <= 1'b0;
            fireAck      <= 1'b0;
            fireDrop     <= 1'b0;
            hitValid     <= 1'b0;
            hitRow       <= '0;
            hitCol       <= '0;
            hitMatch     <= 1'b0;
        end else begin
            fireAck  <= 1'b0;
            fireDrop <= 1'b0;
            if (frameTick)
                frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
            // A wrap landing on the STEP-entry cycle stays pending for the next sweep.
            step_pending <= wrap || (step_pending && state != IDLE);

            case (state)
                IDLE: begin
                    if (step_pending) begin
                        state <= STEP;
                        idx   <= '0;
                    end else if (fireReq) begin
                        if (fireColor == '0 || blockieee > 4'd10 || !have_free) begin
                            fireDrop <= 1'b1;
                        end else begin
                            slots[free_idx] <= '{active: 1'b1, color: fireColor,
                                                 x: 4'd2, y: blockieee};
                            fireAck <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    if (hit) begin
                        hitValid <= 1'b1;
                        hitRow   <= dd_row;
                        hitCol   <= dd_col;
                        hitMatch <= (cell_color == cur.color);
                        state    <= HIT_WAIT;
                    end else begin
                        if (retire)
                            slots[idx] <= '0;
                        else if (cur.active)
                            slots[idx].x <= nx;
                        idx <= last ? '0 : idx + 1'b1;
                        if (last) state <= IDLE;
                    end
                end
                HIT_WAIT: begin
                    if (hitValid && hitReady) begin
                        hitValid <= 1'b0;
`ifdef BULLET_PIERCE_EN
                        if (!hitMatch)
                            slots[idx].x <= nx;
                        else
                            slots[idx] <= '0;
`else
                        slots[idx] <= '0;
`endif
                        idx   <= last ? '0 : idx + 1'b1;
                        state <= last ? IDLE : STEP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Retirement clears the whole record, so colour is already 0 when inactive.
    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_out
        assign bulletBillColor[i] = slots[i].color;
        assign bulletBillXLoc[i]  = slots[i].x;
        assign bulletBillYLoc[i]  = slots[i].y;
    end

endmodule

// File: tb/tb_bullet_bill_scheduler.sv
// Directed bench for bullet_bill_scheduler: fire/drop, stepping, retirement,
// hit handshake and reset during HIT_WAIT (both BULLET_PIERCE_EN builds).
module tb_bullet_bill_scheduler;
    import color_crasher_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  frameTick = 1'b0;
    logic                  fireReq = 1'b0;
    rgb_t                  fireColor = '0;
    logic [3:0]            blockieee = '0;
    rgb_t [0:4][0:5]       ddavers = '0;
    logic                  hitReady = 1'b0;
    logic                  fireAck, fireDrop, hitValid, hitMatch;
    logic [2:0]            hitRow, hitCol;
    rgb_t [0:2]            bulletBillColor;
    logic [0:2][3:0]       bulletBillXLoc, bulletBillYLoc;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bullet_bill_scheduler #(.NUM_BULLETS(3), .MOVE_DIV(4), .X_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .frameTick(frameTick), .fireReq(fireReq),
        .fireColor(fireColor), .blockieee(blockieee), .ddavers(ddavers),
        .hitReady(hitReady), .fireAck(fireAck), .fireDrop(fireDrop),
        .hitValid(hitValid), .hitRow(hitRow), .hitCol(hitCol), .hitMatch(hitMatch),
        .bulletBillColor(bulletBillColor), .bulletBillXLoc(bulletBillXLoc),
        .bulletBillYLoc(bulletBillYLoc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fire(input logic [3:0] y, input rgb_t c);
        blockieee = y;
        fireColor = c;
        fireReq   = 1'b1;
        cyc(1);
        fireReq   = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frameTick = 1'b1;
            cyc(1);
            frameTick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic step_once();
        ticks(4);
        cyc(4);
    endtask

    task automatic wait_hit(input string tag);
        int k = 0;
        while (!hitValid && k < 30) begin
            cyc(1);
            k++;
        end
        check(tag, hitValid, 1'b1);
    endtask

    initial begin
        // Reset state
        cyc(2);
        check("rst_ack", fireAck, 0);
        check("rst_drop", fireDrop, 0);
        check("rst_hitvalid", hitValid, 0);
        check("rst_hitfields", {hitRow, hitCol, hitMatch}, 0);
        check("rst_colors", bulletBillColor, 0);
        check("rst_x", bulletBillXLoc, 0);
        check("rst_y", bulletBillYLoc, 0);
        rst_n = 1'b1;

        // Empty sweeps leave everything quiet
        ticks(8);
        cyc(5);
        check("idle_hitvalid", hitValid, 0);
        check("idle_colors", bulletBillColor, 0);

        // Fill all three slots
        fire(4'd3, 12'hF00);
        check("fire0_ack", fireAck, 1);
        check("fire0_drop", fireDrop, 0);
        check("fire0_color", bulletBillColor[0], 12'hF00);
        check("fire0_x", bulletBillXLoc[0], 2);
        check("fire0_y", bulletBillYLoc[0], 3);
        cyc(1);
        check("fire0_ack_pulse", fireAck, 0);
        fire(4'd0, 12'h0F0);
        check("fire1_ack", fireAck, 1);
        check("fire1_color", bulletBillColor[1], 12'h0F0);
        fire(4'd5, 12'h00F);
        check("fire2_ack", fireAck, 1);
        check("fire2_y", bulletBillYLoc[2], 5);
        fire(4'd7, 12'hFFF);
        check("full_drop", fireDrop, 1);
        check("full_noack", fireAck, 0);
        check("full_colors", bulletBillColor, {12'hF00, 12'h0F0, 12'h00F});

        // One step after four ticks
        ticks(4);
        cyc(4);
        check("step_x", bulletBillXLoc, {4'd3, 4'd3, 4'd3});
        check("step_y1", bulletBillYLoc[1], 0);

        // Matching hit with a stalled consumer
        ddavers[1][0] = 12'hF00;
        ticks(4);
        wait_hit("hit_valid");
        check("hit_row", hitRow, 1);
        check("hit_col", hitCol, 0);
        check("hit_match", hitMatch, 1);
        ddavers[1][0] = '0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("stall_valid", hitValid, 1);
            check("stall_fields", {hitRow, hitCol, hitMatch}, {3'd1, 3'd0, 1'b1});
            check("stall_slot2_x", bulletBillXLoc[2], 3);
        end
        hitReady = 1'b1;
        cyc(1);
        hitReady = 1'b0;
        check("hs_valid_drop", hitValid, 0);
        check("hs_retired", bulletBillColor[0], 0);
        cyc(3);
        check("hs_rest_x", {bulletBillXLoc[1], bulletBillXLoc[2]}, {4'd4, 4'd4});

        // Walk slots 1 and 2 to the right edge, then retire
        repeat (11) step_once();
        check("edge_x", bulletBillXLoc[1], 15);
        check("edge_color", bulletBillColor[1], 12'h0F0);
        step_once();
        check("edge_retired", bulletBillColor, 0);

        // Rejects with free slots available
        fire(4'd3, 12'h000);
        check("zero_color_drop", fireDrop, 1);
        check("zero_color_noalloc", bulletBillColor[0], 0);
        fire(4'd11, 12'hF00);
        check("bad_row_drop", fireDrop, 1);
        check("bad_row_noalloc", bulletBillColor[0], 0);

        // Slot reuse
        fire(4'd3, 12'hF00);
        check("reuse0_ack", fireAck, 1);
        fire(4'd0, 12'h0F0);
        check("reuse1_slot", {bulletBillColor[1], bulletBillXLoc[1], bulletBillYLoc[1]},
              {12'h0F0, 4'd2, 4'd0});
        step_once();
        check("reuse_step", {bulletBillXLoc[0], bulletBillXLoc[1]}, {4'd3, 4'd3});

        // Mismatched hit, consumer ready in advance
        ddavers[1][0] = 12'h0F0;
        hitReady = 1'b1;
        ticks(4);
        wait_hit("mm_valid");
        check("mm_fields", {hitRow, hitCol, hitMatch}, {3'd1, 3'd0, 1'b0});
        cyc(1);
        check("mm_valid_drop", hitValid, 0);
`ifdef BULLET_PIERCE_EN
        check("mm_pierce_x", bulletBillXLoc[0], 4);
        check("mm_pierce_color", bulletBillColor[0], 12'hF00);
`else
        check("mm_retired", bulletBillColor[0], 0);
`endif
        hitReady = 1'b0;
        ddavers = '0;
        cyc(3);
        check("mm_slot1_x", bulletBillXLoc[1], 4);

        // Reset while waiting on a hit
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 6; c++)
                ddavers[r][c] = 12'h111;
        fire(4'd1, 12'h00F);
        check("rh_fire_ack", fireAck, 1);
        step_once();
        check("rh_no_early_hit", hitValid, 0);
        ticks(4);
        wait_hit("rh_valid");
        rst_n = 1'b0;
        #1;
        check("rh_valid_cleared", hitValid, 0);
        check("rh_colors_cleared", bulletBillColor, 0);
        cyc(1);
        rst_n = 1'b1;
        ddavers = '0;
        cyc(1);
        fire(4'd4, 12'hFFF);
        check("post_rst_fire", {fireAck, bulletBillColor[0]}, {1'b1, 12'hFFF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
